// File: rtl/hdc1080_pkg.sv
// Shared types and constants for the HDC1080 I2C measurement sequencer.
package hdc1080_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_CFG_START, ST_CFG_ADDR, ST_CFG_PTR, ST_CFG_MSB, ST_CFG_LSB, ST_CFG_STOP,
        ST_START_W, ST_ADDR_W, ST_PTR, ST_STOP_W,
        ST_WAIT,
        ST_START_R, ST_ADDR_R, ST_RD0, ST_RD1, ST_RD2, ST_RD3, ST_STOP_R,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD_ACK, OP_RD_NACK} op_e;

    typedef logic [1:0] phase_t;

    localparam logic [7:0] PTR_TEMP = 8'h00;
    localparam logic [7:0] PTR_CFG  = 8'h02;

    typedef struct packed {
        op_e        op;
        logic [7:0] wdata;
    } byte_req_t;

endpackage

// File: rtl/hdc1080_i2c_byte.sv
// Tick generator plus bit engine: runs one START, STOP or 9-bit byte op per request.
module hdc1080_i2c_byte
    import hdc1080_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [2:0] op,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       scl_t,
    output logic       sda_t,
    input  logic       sda_i
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active;
    logic [CW-1:0] cnt;
    phase_t        phase;
    logic [3:0]    bitn;
    op_e           op_q;
    logic [7:0]    sr;
    logic          tick, cond, last, wr_op, bit_out;

    assign tick  = active && (cnt == CW'(CLK_DIV - 1));
    assign cond  = (op_q == OP_START) || (op_q == OP_STOP);
    assign last  = cond || (bitn == 4'd8);
    assign wr_op = (op_q == OP_WR);
    assign rdata = sr;

    // Ninth bit: release for the slave ACK on writes, master ACK/NACK on reads.
    always_comb begin
        if (bitn == 4'd8) bit_out = wr_op ? 1'b1 : (op_q == OP_RD_NACK);
        else              bit_out = wr_op ? sr[7] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            phase  <= '0;
            bitn   <= '0;
            op_q   <= OP_START;
            sr     <= '0;
            nack   <= 1'b0;
            ack    <= 1'b0;
            scl_t  <= 1'b1;
            sda_t  <= 1'b1;
        end else begin
            ack <= 1'b0;
            if (!active) begin
                cnt <= '0;
                if (req) begin
                    active <= 1'b1;
                    op_q   <= op_e'(op);
                    sr     <= wdata;
                    phase  <= '0;
                    bitn   <= '0;
                    nack   <= 1'b0;
                end
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt   <= '0;
                phase <= phase + 1'b1;
                case (op_q)
                    OP_START: case (phase)
                        2'd0:    begin scl_t <= 1'b1; sda_t <= 1'b1; end
                        2'd1:    sda_t <= 1'b0;
                        2'd3:    scl_t <= 1'b0;
                        default: ;
                    endcase
                    OP_STOP: case (phase)
                        2'd0:    sda_t <= 1'b0;
                        2'd1:    scl_t <= 1'b1;
                        2'd2:    sda_t <= 1'b1;
                        default: ;
                    endcase
                    default: case (phase)
                        2'd0: sda_t <= bit_out;
                        2'd1: scl_t <= 1'b1;
                        2'd2: begin
                            if (bitn == 4'd8) begin
                                if (wr_op) nack <= sda_i;
                            end else if (!wr_op) begin
                                sr <= {sr[6:0], sda_i};
                            end
                        end
                        default: begin
                            scl_t <= 1'b0;
                            if (wr_op && bitn != 4'd8) sr <= {sr[6:0], 1'b0};
                        end
                    endcase
                endcase
                if (phase == 2'd3) begin
                    if (last) begin
                        active <= 1'b0;
                        ack    <= 1'b1;
                    end else begin
                        bitn <= bitn + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hdc1080_i2c_seq.sv
// HDC1080 measurement sequencer: pointer write, conversion wait, 4-byte read.
// Optional config write before each measurement: define HDC1080_CFG_WRITE_EN.
module hdc1080_i2c_seq
    import hdc1080_pkg::*;
#(
    parameter int         CLK_DIV   = 250,
    parameter logic [6:0] DEV_ADDR  = 7'h40,
    parameter int         CONV_WAIT = 1_500_000
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic [15:0] cfg_word,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [15:0] temp_raw,
    output logic [15:0] humid_raw,
    output logic        scl_t,
    output logic        sda_t,
    input  logic        sda_i
);
    localparam int         WW      = $clog2(CONV_WAIT + 1);
    localparam logic [7:0] ADDR_WR = {DEV_ADDR, 1'b0};
    localparam logic [7:0] ADDR_RD = {DEV_ADDR, 1'b1};

    state_e        state, state_nx, adv;
    byte_req_t     breq;
    logic          b_req, b_ack, b_nack, pend;
    logic [7:0]    b_rdata;
    logic [31:0]   rd_buf;
    logic [WW-1:0] wait_cnt;
    logic          bus_state, wr_state, rd_state;

`ifdef HDC1080_CFG_WRITE_EN
    localparam state_e FIRST_ST = ST_CFG_START;
    logic [15:0] cfg_q;
`else
    localparam state_e FIRST_ST = ST_START_W;
    logic unused_cfg;
    assign unused_cfg = ^cfg_word;
`endif

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign b_req = bus_state && !pend;

    always_comb begin
        state_nx  = state;
        adv       = state;
        breq      = '{op: OP_STOP, wdata: 8'h00};
        bus_state = 1'b1;
        wr_state  = 1'b0;
        rd_state  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus_state = 1'b0;
                if (start) state_nx = FIRST_ST;
            end
`ifdef HDC1080_CFG_WRITE_EN
            ST_CFG_START: begin breq.op = OP_START; adv = ST_CFG_ADDR; end
            ST_CFG_ADDR:  begin breq = '{OP_WR, ADDR_WR};      wr_state = 1'b1; adv = ST_CFG_PTR; end
            ST_CFG_PTR:   begin breq = '{OP_WR, PTR_CFG};      wr_state = 1'b1; adv = ST_CFG_MSB; end
            ST_CFG_MSB:   begin breq = '{OP_WR, cfg_q[15:8]};  wr_state = 1'b1; adv = ST_CFG_LSB; end
            ST_CFG_LSB:   begin breq = '{OP_WR, cfg_q[7:0]};   wr_state = 1'b1; adv = ST_CFG_STOP; end
            ST_CFG_STOP:  adv = ST_START_W;
`endif
            ST_START_W: begin breq.op = OP_START; adv = ST_ADDR_W; end
            ST_ADDR_W:  begin breq = '{OP_WR, ADDR_WR};  wr_state = 1'b1; adv = ST_PTR; end
            ST_PTR:     begin breq = '{OP_WR, PTR_TEMP}; wr_state = 1'b1; adv = ST_STOP_W; end
            ST_STOP_W:  adv = ST_WAIT;
            ST_WAIT: begin
                bus_state = 1'b0;
                if (wait_cnt == WW'(CONV_WAIT - 1)) state_nx = ST_START_R;
            end
            ST_START_R: begin breq.op = OP_START; adv = ST_ADDR_R; end
            ST_ADDR_R:  begin breq = '{OP_WR, ADDR_RD}; wr_state = 1'b1; adv = ST_RD0; end
            ST_RD0:     begin breq.op = OP_RD_ACK;  rd_state = 1'b1; adv = ST_RD1; end
            ST_RD1:     begin breq.op = OP_RD_ACK;  rd_state = 1'b1; adv = ST_RD2; end
            ST_RD2:     begin breq.op = OP_RD_ACK;  rd_state = 1'b1; adv = ST_RD3; end
            ST_RD3:     begin breq.op = OP_RD_NACK; rd_state = 1'b1; adv = ST_STOP_R; end
            ST_STOP_R:  adv = ST_DONE;
            ST_DONE: begin
                bus_state = 1'b0;
                state_nx  = ST_IDLE;
            end
            default: begin
                bus_state = 1'b0;
                state_nx  = ST_IDLE;
            end
        endcase
        // A NACKed write skips straight to the closing STOP.
        if (bus_state && b_ack) state_nx = (wr_state && b_nack) ? ST_STOP_R : adv;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            ack_err   <= 1'b0;
            temp_raw  <= '0;
            humid_raw <= '0;
            rd_buf    <= '0;
            wait_cnt  <= '0;
`ifdef HDC1080_CFG_WRITE_EN
            cfg_q     <= '0;
`endif
        end else begin
            state    <= state_nx;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (b_ack)      pend <= 1'b0;
            else if (b_req) pend <= 1'b1;
            if (state == ST_IDLE && start) begin
                ack_err <= 1'b0;
`ifdef HDC1080_CFG_WRITE_EN
                cfg_q   <= cfg_word;
`endif
            end
            if (b_ack && wr_state && b_nack) ack_err <= 1'b1;
            if (b_ack && rd_state) rd_buf <= {rd_buf[23:0], b_rdata};
            // Results become visible together with done.
            if (b_ack && state == ST_STOP_R && !ack_err) begin
                temp_raw  <= rd_buf[31:16];
                humid_raw <= rd_buf[15:0];
            end
        end
    end

    hdc1080_i2c_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk   (ACLK),
        .rst   (ARESET),
        .req   (b_req),
        .op    (breq.op),
        .wdata (breq.wdata),
        .ack   (b_ack),
        .rdata (b_rdata),
        .nack  (b_nack),
        .scl_t (scl_t),
        .sda_t (sda_t),
        .sda_i (sda_i)
    );

endmodule
